// File: rtl/whack_a_mole_pkg.sv
// Shared definitions for the whack-a-mole mole responder: state codes, LFSR taps and seed.
package whack_a_mole_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_UP      = 3'd2;
  localparam logic [2:0] ST_WHACKED = 3'd3;
  localparam logic [2:0] ST_DOWN    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    SELECT  = ST_SELECT,
    UP      = ST_UP,
    WHACKED = ST_WHACKED,
    DOWN    = ST_DOWN
  } mole_state_t;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a nonzero seed keeps it out of the all-zero lock-up state.
module lfsr16
  import whack_a_mole_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/mole_responder.sv
// Picks a pseudo-random mole per mole_clk up-window, scores button whacks and reports hit/miss.
// Build option: define MOLE_MISS_PENALTY_EN to make every miss cost one point (floored at 0).
//
// state   | meaning
// IDLE    | no game running; outputs low, score held for display
// SELECT  | one cycle: latch a new mole index from the LFSR
// UP      | mole lit; first correct press hits, wrong presses or an escape miss
// WHACKED | mole hit; waiting for the up-window to close
// DOWN    | down-window; waiting for the next mole_clk rise
module mole_responder
  import whack_a_mole_pkg::*;
#(
  parameter int          NUM_MOLES = 4,
  parameter int          SCORE_W   = 8,
  parameter logic [15:0] LFSR_SEED = DEFAULT_LFSR_SEED
)
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         game_in_progress,
  input  logic                         mole_clk,
  input  logic [NUM_MOLES-1:0]         buttons,
  output logic [NUM_MOLES-1:0]         mole_leds,
  output logic [$clog2(NUM_MOLES)-1:0] mole_index,
  output logic                         hit_pulse,
  output logic                         miss_pulse,
  output logic [SCORE_W-1:0]           score
);

  localparam int IW = $clog2(NUM_MOLES);

`ifdef MOLE_MISS_PENALTY_EN
  localparam bit PENALTY = 1'b1;
`else
  localparam bit PENALTY = 1'b0;
`endif

  logic [2:0]           state;
  logic [15:0]          lfsr_q;
  logic                 mole_clk_q;
  logic [NUM_MOLES-1:0] buttons_q;
  logic                 mc_rise;
  logic                 mc_fall;
  logic [NUM_MOLES-1:0] btn_edge;
  logic [IW-1:0]        pick;
  logic [NUM_MOLES-1:0] pick_onehot;
  logic [SCORE_W-1:0]   score_after_miss;
  logic                 unused_lfsr_bits;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign mc_rise     = mole_clk & ~mole_clk_q;
  assign mc_fall     = ~mole_clk & mole_clk_q;
  assign btn_edge    = buttons & ~buttons_q;
  assign pick        = lfsr_q[IW-1:0];
  assign pick_onehot = {{(NUM_MOLES-1){1'b0}}, 1'b1} << pick;
  assign score_after_miss = (PENALTY && score != '0) ? score - 1'b1 : score;
  assign unused_lfsr_bits = ^lfsr_q[15:IW];

  always_ff @(posedge clk) begin
    if (rst) begin
      mole_clk_q <= 1'b0;
      buttons_q  <= '0;
    end else begin
      mole_clk_q <= mole_clk;
      buttons_q  <= buttons;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mole_leds  <= '0;
      mole_index <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score      <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      // Game end overrides every other transition, including a pending hit or miss.
      if (state != ST_IDLE && !game_in_progress) begin
        state     <= ST_IDLE;
        mole_leds <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (mc_rise && game_in_progress) begin
              score <= '0;
              state <= ST_SELECT;
            end
          end
          ST_SELECT: begin
            mole_index <= pick;
            mole_leds  <= pick_onehot;
            state      <= ST_UP;
          end
          ST_UP: begin
            if (btn_edge[mole_index]) begin
              hit_pulse <= 1'b1;
              if (score != '1) score <= score + 1'b1;
              mole_leds <= '0;
              state     <= ST_WHACKED;
            end else if (|btn_edge) begin
              miss_pulse <= 1'b1;
              score      <= score_after_miss;
            end else if (mc_fall) begin
              miss_pulse <= 1'b1;
              score      <= score_after_miss;
              mole_leds  <= '0;
              state      <= ST_DOWN;
            end
          end
          // Level check so a hit landing on the falling edge still reaches DOWN.
          ST_WHACKED: begin
            if (!mole_clk) state <= ST_DOWN;
          end
          ST_DOWN: begin
            if (mc_rise) state <= ST_SELECT;
          end
          default: begin
            state     <= ST_IDLE;
            mole_leds <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_responder.sv
// Randomized scoreboard bench for mole_responder against a game-rule reference model.
module tb_mole_responder;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int SW = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          gip = 1'b0;
  logic          mole_clk = 1'b0;
  logic [N-1:0]  buttons = '0;
  logic [N-1:0]  mole_leds;
  logic [IW-1:0] mole_index;
  logic          hit_pulse;
  logic          miss_pulse;
  logic [SW-1:0] score;

  int checks = 0;
  int errors = 0;

  mole_responder #(.NUM_MOLES(N), .SCORE_W(SW), .LFSR_SEED(SEED)) dut (
    .clk              (clk),
    .rst              (rst),
    .game_in_progress (gip),
    .mole_clk         (mole_clk),
    .buttons          (buttons),
    .mole_leds        (mole_leds),
    .mole_index       (mole_index),
    .hit_pulse        (hit_pulse),
    .miss_pulse       (miss_pulse),
    .score            (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  leds;
    logic [IW-1:0] idx;
    logic          hit;
    logic          miss;
    logic [SW-1:0] score;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: game rules expressed as a few flags, evaluated once per clock.
  bit [15:0] m_lfsr = SEED;
  bit        m_mc_prev = 0;
  bit [N-1:0] m_btn_prev = '0;
  bit        playing = 0, pick_pending = 0, mole_out = 0, hit_wait = 0;
  int        m_idx = 0;
  int        m_score = 0;

  always @(posedge clk) begin
    bit rise, fall, hit, miss;
    bit [N-1:0] presses;
    exp_t e;
    rise    = mole_clk && !m_mc_prev;
    fall    = !mole_clk && m_mc_prev;
    presses = buttons & ~m_btn_prev;
    hit = 0;
    miss = 0;
    if (rst) begin
      playing = 0; pick_pending = 0; mole_out = 0; hit_wait = 0;
      m_idx = 0; m_score = 0; m_lfsr = SEED;
      m_mc_prev = 0; m_btn_prev = '0;
    end else begin
      if (playing && !gip) begin
        playing = 0; pick_pending = 0; mole_out = 0; hit_wait = 0;
      end else if (!playing) begin
        if (rise && gip) begin
          playing = 1; pick_pending = 1; m_score = 0;
        end
      end else if (pick_pending) begin
        m_idx = m_lfsr % N;
        pick_pending = 0;
        mole_out = 1;
      end else if (mole_out) begin
        if (presses[m_idx]) begin
          hit = 1;
          if (m_score < (1 << SW) - 1) m_score++;
          mole_out = 0;
          hit_wait = 1;
        end else if (presses != 0) begin
          miss = 1;
        end else if (fall) begin
          miss = 1;
          mole_out = 0;
        end
      end else if (hit_wait) begin
        if (!mole_clk) hit_wait = 0;
      end else begin
        if (rise) pick_pending = 1;
      end
`ifdef MOLE_MISS_PENALTY_EN
      if (miss && m_score > 0) m_score--;
`endif
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      m_mc_prev  = mole_clk;
      m_btn_prev = buttons;
    end
    e.leds  = mole_out ? N'(1 << m_idx) : '0;
    e.idx   = IW'(m_idx);
    e.hit   = hit;
    e.miss  = miss;
    e.score = SW'(m_score);
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (mole_leds !== e.leds) begin
        errors++;
        $display("FAIL mole_leds t=%0t got %b want %b", $time, mole_leds, e.leds);
      end
      checks++;
      if (mole_index !== e.idx) begin
        errors++;
        $display("FAIL mole_index t=%0t got %0d want %0d", $time, mole_index, e.idx);
      end
      checks++;
      if (hit_pulse !== e.hit) begin
        errors++;
        $display("FAIL hit_pulse t=%0t got %b want %b", $time, hit_pulse, e.hit);
      end
      checks++;
      if (miss_pulse !== e.miss) begin
        errors++;
        $display("FAIL miss_pulse t=%0t got %b want %b", $time, miss_pulse, e.miss);
      end
      checks++;
      if (score !== e.score) begin
        errors++;
        $display("FAIL score t=%0t got %0d want %0d", $time, score, e.score);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_seed();
    checks++;
    if (dut.u_lfsr.q !== SEED) begin
      errors++;
      $display("FAIL lfsr_reload got %h want %h", dut.u_lfsr.q, SEED);
    end
  endtask

  task automatic press(input int b);
    buttons = '0;
    buttons[b] = 1'b1;
    tick(1);
    buttons = '0;
  endtask

  // One full window: rise, optionally whack the shown mole, fall, rest in the down-window.
  task automatic window(input bit do_hit);
    mole_clk = 1'b1;
    tick(2);
    if (do_hit) press(m_idx);
    tick(1);
    mole_clk = 1'b0;
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    tick(3);
    check_seed();
    rst = 1'b0;
    tick(2);

    // First mole and a correct whack, then a repeat press in the same window.
    gip = 1'b1;
    tick(5);
    mole_clk = 1'b1;
    tick(2);
    press(m_idx);
    tick(2);
    press(m_idx);
    tick(2);
    mole_clk = 1'b0;
    tick(3);

    // Wrong buttons first, then the correct one.
    mole_clk = 1'b1;
    tick(2);
    press((m_idx + 1) % N);
    tick(1);
    press((m_idx + 2) % N);
    tick(1);
    buttons = '1;
    tick(1);
    buttons = '0;
    tick(1);
    mole_clk = 1'b0;
    tick(3);

    // Escaped mole, then a hit landing on the falling edge.
    window(0);
    mole_clk = 1'b1;
    tick(2);
    buttons[m_idx] = 1'b1;
    mole_clk = 1'b0;
    tick(1);
    buttons = '0;
    tick(3);

    // Game ends while a mole is up; score must freeze.
    mole_clk = 1'b1;
    tick(2);
    gip = 1'b0;
    tick(3);
    mole_clk = 1'b0;
    tick(3);

    // Reset while a mole is up.
    gip = 1'b1;
    mole_clk = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    check_seed();
    rst = 1'b0;
    mole_clk = 1'b0;
    tick(2);

    // Randomized play.
    for (int c = 0; c < 1500; c++) begin
      int r;
      if ($urandom_range(5) == 0) mole_clk = ~mole_clk;
      r = $urandom_range(9);
      if (r < 5) buttons = '0;
      else if (r < 8) begin
        buttons = '0;
        buttons[m_idx] = 1'b1;
      end else buttons = N'($urandom);
      if ($urandom_range(79) == 0) gip = ~gip;
      if (!gip && $urandom_range(7) == 0) gip = 1'b1;
      rst = ($urandom_range(299) == 0);
      tick(1);
    end
    rst = 1'b0;
    buttons = '0;
    mole_clk = 1'b0;
    gip = 1'b0;
    tick(3);

    // Saturation: a long game of perfect whacks pushes the score past all-ones.
    gip = 1'b1;
    for (int w = 0; w < 260; w++) window(1);
    // Saturated hit on the falling edge.
    mole_clk = 1'b1;
    tick(2);
    buttons[m_idx] = 1'b1;
    mole_clk = 1'b0;
    tick(1);
    buttons = '0;
    tick(3);
    window(0);
    gip = 1'b0;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
